// File: rtl/rv32i_uart_pkg.sv
// Shared register map, bit positions and transmitter state encoding for the MMIO UART.
// Constants only: no logic, no latency, no flow control.
package rv32i_uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_IRQ     = 4;
    localparam int ST_CNT_LSB = 8;

    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; dout shows the head combinationally, push/pop take effect at the edge.
// Backpressure: a push when full and a pop when empty are ignored; the caller watches full/empty.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_uart_tx_mmio.sv
// MMIO 8N1 UART transmitter: combinational hit/rdata, txd falls one edge after a push into an idle, empty FIFO.
// Full FIFO drops writes and sets sticky ovf; optional irq output under `UART_TX_IRQ_EN.
module rv32i_uart_tx_mmio
    import rv32i_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Memwrite,
    input  logic [31:0] Memaddr,
    input  logic [31:0] MemWdata,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        uart_txd
`ifdef UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int BCNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [BCNT_W-1:0] BCNT_RELOAD = BCNT_W'(CLKS_PER_BIT - 1);

    tx_state_t         state;
    logic [BCNT_W-1:0] bcnt;
    logic [2:0]        bidx;
    logic [7:0]        shreg;
    logic              tx_en;
    logic              ovf;

    logic [1:0]        offset;
    logic              wr;
    logic              push;
    logic              pop;
    logic              busy;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              unused_bits;

    assign hit    = (Memaddr[31:4] == BASE_ADDR[31:4]);
    assign offset = Memaddr[3:2];
    assign wr     = Memwrite & hit;
    assign push   = wr && (offset == REG_TXDATA);
    assign busy   = (state != S_IDLE);
    assign pop    = (state == S_IDLE) && tx_en && !fifo_empty;

    assign unused_bits = ^{Memaddr[1:0], MemWdata[31:8]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (MemWdata[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef UART_TX_IRQ_EN
    logic irq_en;
`endif

    // Register file; an overflowing push beats a same-edge ovf clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_en <= 1'b1;
            ovf   <= 1'b0;
`ifdef UART_TX_IRQ_EN
            irq_en <= 1'b0;
            irq    <= 1'b0;
`endif
        end else begin
            if (push && fifo_full)
                ovf <= 1'b1;
            else if (wr && offset == REG_STATUS && MemWdata[ST_OVF])
                ovf <= 1'b0;
            if (wr && offset == REG_CTRL) begin
                tx_en <= MemWdata[CTRL_TX_EN];
`ifdef UART_TX_IRQ_EN
                irq_en <= MemWdata[CTRL_IRQ_EN];
`endif
            end
`ifdef UART_TX_IRQ_EN
            irq <= irq_en & fifo_empty & ~busy;
`endif
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (offset)
                REG_STATUS: begin
                    rdata[ST_FULL]             = fifo_full;
                    rdata[ST_EMPTY]            = fifo_empty;
                    rdata[ST_BUSY]             = busy;
                    rdata[ST_OVF]              = ovf;
                    rdata[ST_CNT_LSB +: CW]    = fifo_count;
`ifdef UART_TX_IRQ_EN
                    rdata[ST_IRQ]              = irq;
`endif
                end
                REG_CTRL: begin
                    rdata[CTRL_TX_EN]  = tx_en;
`ifdef UART_TX_IRQ_EN
                    rdata[CTRL_IRQ_EN] = irq_en;
`endif
                end
                default: rdata = '0;
            endcase
        end
    end

    // txd is registered and updated on the same edge as each state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            bcnt     <= '0;
            bidx     <= '0;
            shreg    <= '0;
            uart_txd <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    uart_txd <= 1'b1;
                    if (pop) begin
                        shreg    <= fifo_dout;
                        bcnt     <= BCNT_RELOAD;
                        state    <= S_START;
                        uart_txd <= 1'b0;
                    end
                end
                S_START: begin
                    if (bcnt == '0) begin
                        bcnt     <= BCNT_RELOAD;
                        bidx     <= '0;
                        state    <= S_DATA;
                        uart_txd <= shreg[0];
                    end else begin
                        bcnt <= bcnt - BCNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bcnt == '0) begin
                        shreg <= {1'b0, shreg[7:1]};
                        bcnt  <= BCNT_RELOAD;
                        if (bidx == 3'd7) begin
                            state    <= S_STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            bidx     <= bidx + 3'd1;
                            uart_txd <= shreg[1];
                        end
                    end else begin
                        bcnt <= bcnt - BCNT_W'(1);
                    end
                end
                S_STOP: begin
                    uart_txd <= 1'b1;
                    if (bcnt == '0)
                        state <= S_IDLE;
                    else
                        bcnt <= bcnt - BCNT_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_uart_tx_mmio.sv
// Directed bench for rv32i_uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Inputs change and outputs are sampled 1ns after rising edges.
module tb_rv32i_uart_tx_mmio;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_CT = BASE + 32'h8;
    localparam logic [31:0] A_RS = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Memwrite = 1'b0;
    logic [31:0] Memaddr = 32'h0;
    logic [31:0] MemWdata = 32'h0;
    logic        hit;
    logic [31:0] rdata;
    logic        uart_txd;
`ifdef UART_TX_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int failures = 0;

    rv32i_uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Memwrite (Memwrite),
        .Memaddr  (Memaddr),
        .MemWdata (MemWdata),
        .hit      (hit),
        .rdata    (rdata),
        .uart_txd (uart_txd)
`ifdef UART_TX_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        Memwrite = 1'b1;
        Memaddr  = addr;
        MemWdata = data;
        @(posedge clk);
        #1;
        Memwrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        Memwrite = 1'b0;
        Memaddr  = addr;
        #1;
        data = rdata;
    endtask

    function automatic logic [63:0] frame_bits(input logic [7:0] b);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       f[i] = 1'b0;
            else if (i < 36) f[i] = b[(i - 4) / 4];
            else             f[i] = 1'b1;
        end
        return f;
    endfunction

    // obs[0] is the current sample; 39 further samples follow, one per edge.
    task automatic capture_frame(output logic [63:0] obs);
        obs = '0;
        obs[0] = uart_txd;
        for (int i = 1; i < 40; i++) begin
            @(posedge clk);
            #1;
            obs[i] = uart_txd;
        end
    endtask

    task automatic wait_start(input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (uart_txd == 1'b0) seen = 1'b1;
        end
        check(tag, {63'd0, seen}, 64'd1);
    endtask

    task automatic check_quiet(input int cycles, input string tag);
        bit low;
        low = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (uart_txd == 1'b0) low = 1'b1;
        end
        check(tag, {63'd0, low}, 64'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [63:0] obs;

        #23;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_txd", {63'd0, uart_txd}, 64'd1);
        bus_read(A_ST, rd);
        check("rst_status", {32'd0, rd}, 64'h0002);
        bus_read(A_CT, rd);
        check("rst_ctrl", {32'd0, rd}, 64'h0001);

        // Basic frame: txd falls one edge after the write edge
        bus_write(A_TX, 32'h55);
        check("basic_pre", {63'd0, uart_txd}, 64'd1);
        @(posedge clk);
        #1;
        capture_frame(obs);
        check("basic_frame", obs, frame_bits(8'h55));
        bus_read(A_ST, rd);
        check("basic_busy", {32'd0, rd}, 64'h0006);
        @(posedge clk);
        #1;
        bus_read(A_ST, rd);
        check("basic_done", {32'd0, rd}, 64'h0002);
        bus_read(A_TX, rd);
        check("txdata_read", {32'd0, rd}, 64'h0);

        // Overflow with transmitter disabled
        bus_write(A_CT, 32'h0);
        for (int i = 0; i < 9; i++) bus_write(A_TX, 32'h10 + i);
        bus_read(A_ST, rd);
        check("ovf_status", {32'd0, rd}, 64'h0809);
        check_quiet(8, "ovf_held");
        bus_write(A_ST, 32'h8);
        bus_read(A_ST, rd);
        check("ovf_clear", {32'd0, rd}, 64'h0801);
        bus_read(A_CT, rd);
        check("ctrl_off", {32'd0, rd}, 64'h0);
        bus_write(A_CT, 32'h1);
        for (int i = 0; i < 8; i++) begin
            wait_start(8, "ovf_start");
            capture_frame(obs);
            check("ovf_frame", obs, frame_bits(8'h10 + 8'(i)));
        end
        check_quiet(60, "ovf_no_9th");
        bus_read(A_ST, rd);
        check("ovf_end", {32'd0, rd}, 64'h0002);

        // Back-to-back writes: one idle cycle between frames
        bus_write(A_TX, 32'hA5);
        bus_write(A_TX, 32'h3C);
        capture_frame(obs);
        check("b2b_frame1", obs, frame_bits(8'hA5));
        @(posedge clk);
        #1;
        check("b2b_gap", {63'd0, uart_txd}, 64'd1);
        @(posedge clk);
        #1;
        capture_frame(obs);
        check("b2b_frame2", obs, frame_bits(8'h3C));
        check("b2b_3c_bits", obs[39:0], {4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0});
        check_quiet(10, "b2b_tail");

        // Reset in the middle of bit 3 of 0xFF, two bytes queued
        bus_write(A_TX, 32'hFF);
        bus_write(A_TX, 32'h01);
        bus_write(A_TX, 32'h02);
        bus_read(A_ST, rd);
        check("mid_status", {32'd0, rd}, 64'h0204);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_txd", {63'd0, uart_txd}, 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_read(A_ST, rd);
        check("mid_rst_status", {32'd0, rd}, 64'h0002);
        bus_read(A_CT, rd);
        check("mid_rst_ctrl", {32'd0, rd}, 64'h0001);
        check_quiet(60, "mid_no_frames");

        // Address decode
        Memwrite = 1'b1;
        Memaddr  = 32'hFFFF_0010;
        MemWdata = 32'h77;
        #1;
        check("dec_hit_10", {63'd0, hit}, 64'd0);
        check("dec_rdata_10", {32'd0, rdata}, 64'd0);
        @(posedge clk);
        #1;
        Memaddr = 32'h0000_1000;
        #1;
        check("dec_hit_1000", {63'd0, hit}, 64'd0);
        check("dec_rdata_1000", {32'd0, rdata}, 64'd0);
        @(posedge clk);
        #1;
        Memwrite = 1'b0;
        bus_read(A_ST, rd);
        check("dec_no_push", {32'd0, rd}, 64'h0002);
        bus_write(A_RS, 32'hFFFF_FFFF);
        bus_read(A_RS, rd);
        check("dec_hit_c", {63'd0, hit}, 64'd1);
        check("dec_rdata_c", {32'd0, rd}, 64'd0);
        bus_read(BASE + 32'h6, rd);
        check("dec_low_bits", {32'd0, rd}, 64'h0002);
        bus_read(A_CT, rd);
        check("dec_ctrl_kept", {32'd0, rd}, 64'h0001);
        check_quiet(6, "dec_quiet");

`ifdef UART_TX_IRQ_EN
        bus_write(A_CT, 32'h3);
        bus_read(A_CT, rd);
        check("irq_ctrl", {32'd0, rd}, 64'h0003);
        bus_write(A_TX, 32'h81);
        @(posedge clk);
        #1;
        capture_frame(obs);
        check("irq_frame", obs, frame_bits(8'h81));
        check("irq_low_in_frame", {63'd0, irq}, 64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("irq_set", {63'd0, irq}, 64'd1);
        bus_read(A_ST, rd);
        check("irq_status", {32'd0, rd}, 64'h0012);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rv32i_uart_tx_mmio.md
Name: rv32i_uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the CPU data bus, downstream of the CPU data-memory port.
- Decodes `Memaddr` against a base window and accepts byte writes into a TX FIFO.
- Serialises the bytes 8N1 on `uart_txd`.
- Returns status and control words combinationally on reads, because the single-cycle CPU consumes read data in the same cycle.
- The top-level bus mux selects `rdata` whenever `hit` is high.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, base of the 16-byte register window; bits [3:0] are ignored.
- CLKS_PER_BIT, 434, clk cycles per serial bit; must be >= 2.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, 2..128.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- Memwrite  in  1  CPU store strobe.
- Memaddr  in  32  CPU data address.
- MemWdata  in  32  CPU store data.
- hit  out  1  Memaddr is inside the window (combinational).
- rdata  out  32  register read data (combinational).
- uart_txd  out  1  serial output, idle high, registered.

Behaviour:
- Clock and reset: clock `clk`; reset `reset`, asynchronous, active-high.
- Decode: `hit = (Memaddr[31:4] == BASE_ADDR[31:4])`. The register offset is `Memaddr[3:2]`; `Memaddr[1:0]` is ignored.
- Offset 0x0, TXDATA:
  - Write: a write (`Memwrite & hit`) at a clk edge pushes `MemWdata[7:0]`.
  - If the FIFO is full at that edge, the byte is dropped and sticky `ovf` is set. Fullness is evaluated before a same-edge pop, so a push to a full FIFO is dropped even if a pop occurs at the same edge.
  - Read: returns 0.
- Offset 0x4, STATUS (read):
  - bit0 = full, bit1 = empty, bit2 = busy (FSM not IDLE), bit3 = ovf.
  - [15:8] = FIFO count; all other bits 0.
  - Write with `MemWdata[3]=1` clears ovf. If an overflowing push and the clear occur at the same edge, set wins.
- Offset 0x8, CTRL: bit0 = tx_en, reset value 1. Readable and writable; other bits read 0.
- Offset 0xC: reads 0; writes ignored.
- `rdata` is 0 when `hit` = 0.
- FSM states: IDLE, START, DATA, STOP. Baud counter `bcnt` runs from CLKS_PER_BIT-1 down to 0; bit index `bidx` is 0..7.
  - IDLE: `txd`=1. If tx_en and FIFO not empty: pop the head into the shift register, load `bcnt`, go to START.
  - START: `txd`=0. When `bcnt`=0, reload `bcnt`, set `bidx`=0, go to DATA.
  - DATA: `txd` = shift register bit 0, LSB first. When `bcnt`=0: shift right; if `bidx`=7 go to STOP, otherwise increment `bidx`; reload `bcnt`.
  - STOP: `txd`=1. When `bcnt`=0, go to IDLE.
- Timing:
  - A push at edge N into an empty FIFO in IDLE causes `txd` to fall at edge N+1.
  - Each frame is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by exactly 1 extra idle-high cycle (the IDLE state).
- tx_en cleared mid-frame: the current frame completes; the FSM then holds in IDLE.
- Reset values: `txd`=1, FSM=IDLE, FIFO empty, ovf=0, tx_en=1, `bcnt`=0, `bidx`=0, shift register=0. `rdata`/`hit` follow their inputs.
- Reset mid-frame aborts the frame immediately and flushes the FIFO.
- FIFO: count width is clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.

Optional Feature:
UART_TX_IRQ_EN.
- Defined:
  - Adds output port `irq` (1 bit), registered, reset value 0, and CTRL bit1 = irq_en (reset 0).
  - `irq` = irq_en & empty & ~busy, evaluated at each edge; it asserts once all data has drained.
  - STATUS bit4 mirrors `irq`.
- Undefined: no `irq` port; CTRL bit1 and STATUS bit4 read 0 and writes to them are ignored.

Decomposition:
- Shared package `rv32i_uart_pkg`:
  - Register offset constants (TXDATA=2'd0, STATUS=2'd1, CTRL=2'd2).
  - STATUS and CTRL bit-position constants.
  - FSM state enum (2-bit: IDLE, START, DATA, STOP).
- One sub-module, `uart_tx_fifo`: synchronous FIFO parameterised by DEPTH and WIDTH=8, with push, pop, dout, full, empty and count ports.

Test Plan:
All scenarios use CLKS_PER_BIT=4, FIFO_DEPTH=8, BASE_ADDR=32'hFFFF_0000.
- Basic frame: store 0x55 to 0xFFFF0000 → `txd` low 4 cycles starting 1 cycle after the write edge, then data 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles. Reads of 0xFFFF0004: busy=1 during the frame; STATUS=0x0002 after.
- Overflow: set CTRL=0, store 9 bytes → STATUS reads 0x0809 (count 8, full, ovf). Store 0x8 to STATUS → ovf clears, STATUS=0x0801. Set CTRL=1 → the first 8 bytes transmit in order; the 9th never appears.
- Back-to-back: store 0xA5 and 0x3C in consecutive cycles → two frames 40 cycles each, separated by exactly 1 high cycle; 0x3C sent LSB first as 0,0,1,1,1,1,0,0.
- Reset mid-frame: assert reset during bit 3 of 0xFF with 2 bytes queued → `txd`=1 immediately, STATUS=0x0002, CTRL=0x1 after release; no further frames.
- Decode: store to 0xFFFF0010 and 0x00001000 → `hit`=0, no push, `rdata`=0. A read of 0xFFFF000C returns 0 with `hit`=1.
- IRQ (UART_TX_IRQ_EN): set CTRL=0x3, send 1 byte → `irq`=0 during the frame, `irq`=1 within 1 cycle of the return to IDLE, STATUS bit4=1.
